// File: rtl/kd_tree_query_scheduler_if.sv
// Bundle of every handshake/data signal between the KD-tree query scheduler and
// its environment (node loader, two query requesters, tree block, result sink).
interface kd_tree_query_scheduler_if #(
    parameter int PATCH_WIDTH    = 55,
    parameter int INTERNAL_WIDTH = 22,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int TAG_WIDTH      = 8
);
    logic                      start;
    logic                      flush;
    logic                      node_valid;
    logic [INTERNAL_WIDTH-1:0] node_data;
    logic                      node_ready;
    logic                      tree_fsm_enable;
    logic                      tree_sender_enable;
    logic [INTERNAL_WIDTH-1:0] tree_sender_data;
    logic                      qa_valid;
    logic                      qb_valid;
    logic [PATCH_WIDTH-1:0]    qa_patch;
    logic [PATCH_WIDTH-1:0]    qb_patch;
    logic [TAG_WIDTH-1:0]      qa_tag;
    logic [TAG_WIDTH-1:0]      qb_tag;
    logic                      qa_ready;
    logic                      qb_ready;
    logic                      tree_patch_en;
    logic                      tree_patch_two_en;
    logic [PATCH_WIDTH-1:0]    tree_patch_in;
    logic [PATCH_WIDTH-1:0]    tree_patch_in_two;
    logic                      tree_receiver_en;
    logic                      tree_receiver_two_en;
    logic [ADDRESS_WIDTH-1:0]  tree_leaf_index;
    logic [ADDRESS_WIDTH-1:0]  tree_leaf_index_two;
    logic                      res_valid;
    logic                      res_ready;
    logic [ADDRESS_WIDTH-1:0]  res_leaf;
    logic [TAG_WIDTH-1:0]      res_tag;
    logic                      res_lane;
    logic                      load_done;
    logic                      done;
    logic                      err;

    modport slave (
        input  start, flush, node_valid, node_data,
        input  qa_valid, qb_valid, qa_patch, qb_patch, qa_tag, qb_tag,
        input  tree_receiver_en, tree_receiver_two_en, tree_leaf_index, tree_leaf_index_two,
        input  res_ready,
        output node_ready, tree_fsm_enable, tree_sender_enable, tree_sender_data,
        output qa_ready, qb_ready, tree_patch_en, tree_patch_two_en, tree_patch_in, tree_patch_in_two,
        output res_valid, res_leaf, res_tag, res_lane, load_done, done, err
    );

    modport master (
        output start, flush, node_valid, node_data,
        output qa_valid, qb_valid, qa_patch, qb_patch, qa_tag, qb_tag,
        output tree_receiver_en, tree_receiver_two_en, tree_leaf_index, tree_leaf_index_two,
        output res_ready,
        input  node_ready, tree_fsm_enable, tree_sender_enable, tree_sender_data,
        input  qa_ready, qb_ready, tree_patch_en, tree_patch_two_en, tree_patch_in, tree_patch_in_two,
        input  res_valid, res_leaf, res_tag, res_lane, load_done, done, err
    );
endinterface

// File: rtl/kd_tree_query_scheduler.sv
// Two-phase sequencer for the KD-tree internal-node block: streams the node words
// in, then issues credit-limited queries on two lanes and merges tagged results.
module kd_tree_query_scheduler #(
    parameter int PATCH_WIDTH    = 55,
    parameter int INTERNAL_WIDTH = 22,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int NUM_NODES      = 63,
    parameter int TREE_LATENCY   = 6,
    parameter int TAG_WIDTH      = 8,
    parameter int RESULT_DEPTH   = 8
) (
    input logic                      clk,
    input logic                      rst_n,
    kd_tree_query_scheduler_if.slave bus
);
    localparam int CW = $clog2(RESULT_DEPTH + 2 * TREE_LATENCY + 4) + 1;
    localparam int PW = $clog2(RESULT_DEPTH);
    localparam int NW = $clog2(NUM_NODES + 1);
    localparam int EW = ADDRESS_WIDTH + TAG_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C     = CW'(RESULT_DEPTH);
    localparam logic [NW-1:0] LAST_NODE_C = NW'(NUM_NODES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_QUERY = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    state_e              state_q;
    logic [NW-1:0]       node_cnt_q;
    logic                load_done_q;
    logic                done_q;
    logic                err_q;
    logic                rr_q;

    logic [TREE_LATENCY-1:0] dl0_vld_q;
    logic [TREE_LATENCY-1:0] dl1_vld_q;
    logic [TAG_WIDTH-1:0]    dl0_tag_q [TREE_LATENCY];
    logic [TAG_WIDTH-1:0]    dl1_tag_q [TREE_LATENCY];

    logic [EW-1:0]       fifo_mem_q [RESULT_DEPTH];
    logic [PW-1:0]       rd_ptr_q;
    logic [PW-1:0]       wr_ptr_q;
    logic [CW-1:0]       fifo_cnt_q;

    logic                node_accept_s;
    logic                qa_ready_s;
    logic                qb_ready_s;
    logic                contested_s;
    logic                issue_a_s;
    logic                issue_b_s;
    logic [CW-1:0]       inflight_s;
    logic [CW-1:0]       used_s;
    logic                free_ge2_s;
    logic                free_eq1_s;
    logic                res_valid_s;
    logic                pop_s;
    logic [CW-1:0]       space_s;
    logic                wr0_s;
    logic                wr1_s;
    logic [PW-1:0]       wr1_ptr_s;
    logic [EW-1:0]       entry0_s;
    logic [EW-1:0]       entry1_s;
    logic [EW-1:0]       head_s;
    logic                err_s;

    function automatic logic [CW-1:0] count_ones(input logic [TREE_LATENCY-1:0] v);
        logic [CW-1:0] n;
        n = {CW{1'b0}};
        for (int i = 0; i < TREE_LATENCY; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    assign node_accept_s = (state_q == ST_LOAD) && bus.node_valid;
    assign inflight_s    = count_ones(dl0_vld_q) + count_ones(dl1_vld_q);
    assign used_s        = fifo_cnt_q + inflight_s;
    // Credits count only registered occupancy so a same-cycle pop never funds an issue.
    assign free_ge2_s    = (used_s + CW'(2)) <= DEPTH_C;
    assign free_eq1_s    = (used_s + CW'(1)) == DEPTH_C;
    assign issue_a_s     = bus.qa_valid && qa_ready_s;
    assign issue_b_s     = bus.qb_valid && qb_ready_s;

    // Query admission: credit split across lanes with round-robin on the last credit.
    always_comb begin
        qa_ready_s  = 1'b0;
        qb_ready_s  = 1'b0;
        contested_s = 1'b0;
        if ((state_q == ST_QUERY) && !bus.flush) begin
            if (free_ge2_s) begin
                qa_ready_s = 1'b1;
                qb_ready_s = 1'b1;
            end else if (free_eq1_s) begin
                if (bus.qa_valid && bus.qb_valid) begin
                    contested_s = 1'b1;
                    if (rr_q) begin
                        qb_ready_s = 1'b1;
                    end else begin
                        qa_ready_s = 1'b1;
                    end
                end else if (bus.qa_valid) begin
                    qa_ready_s = 1'b1;
                end else if (bus.qb_valid) begin
                    qb_ready_s = 1'b1;
                end else begin
                    qa_ready_s = 1'b0;
                    qb_ready_s = 1'b0;
                end
            end else begin
                qa_ready_s = 1'b0;
                qb_ready_s = 1'b0;
            end
        end else begin
            qa_ready_s = 1'b0;
            qb_ready_s = 1'b0;
        end
    end

    assign res_valid_s = (fifo_cnt_q != {CW{1'b0}});
    assign pop_s       = res_valid_s && bus.res_ready;
    assign space_s     = (DEPTH_C - fifo_cnt_q) + CW'(pop_s);
    assign wr0_s       = bus.tree_receiver_en && (space_s >= CW'(1));
    assign wr1_s       = bus.tree_receiver_two_en && (space_s >= (wr0_s ? CW'(2) : CW'(1)));
    assign wr1_ptr_s   = wr_ptr_q + PW'(wr0_s);
    assign entry0_s    = {bus.tree_leaf_index, dl0_tag_q[TREE_LATENCY-1], 1'b0};
    assign entry1_s    = {bus.tree_leaf_index_two, dl1_tag_q[TREE_LATENCY-1], 1'b1};
    assign head_s      = fifo_mem_q[rd_ptr_q];
    assign err_s       = (bus.tree_receiver_en != dl0_vld_q[TREE_LATENCY-1])
                       || (bus.tree_receiver_two_en != dl1_vld_q[TREE_LATENCY-1])
                       || (bus.tree_receiver_en && !wr0_s)
                       || (bus.tree_receiver_two_en && !wr1_s);

    // Phase sequencer with its pulse/sticky status outputs and the RR pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            node_cnt_q  <= {NW{1'b0}};
            load_done_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rr_q        <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= err_q || err_s;
            case (state_q)
                ST_IDLE: begin
                    node_cnt_q <= {NW{1'b0}};
                    if (bus.start) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (node_accept_s) begin
                        if (node_cnt_q == LAST_NODE_C) begin
                            node_cnt_q  <= {NW{1'b0}};
                            load_done_q <= 1'b1;
                            state_q     <= ST_QUERY;
                        end else begin
                            node_cnt_q <= node_cnt_q + NW'(1);
                        end
                    end
                end
                ST_QUERY: begin
                    if (contested_s) begin
                        rr_q <= ~rr_q;
                    end
                    if (bus.flush) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((inflight_s == {CW{1'b0}}) && (fifo_cnt_q == {CW{1'b0}})) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-lane tag delay lines aligned to the tree's fixed pipeline depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl0_vld_q <= {TREE_LATENCY{1'b0}};
            dl1_vld_q <= {TREE_LATENCY{1'b0}};
            for (int i = 0; i < TREE_LATENCY; i++) begin
                dl0_tag_q[i] <= {TAG_WIDTH{1'b0}};
                dl1_tag_q[i] <= {TAG_WIDTH{1'b0}};
            end
        end else begin
            dl0_vld_q    <= {dl0_vld_q[TREE_LATENCY-2:0], issue_a_s};
            dl1_vld_q    <= {dl1_vld_q[TREE_LATENCY-2:0], issue_b_s};
            dl0_tag_q[0] <= issue_a_s ? bus.qa_tag : {TAG_WIDTH{1'b0}};
            dl1_tag_q[0] <= issue_b_s ? bus.qb_tag : {TAG_WIDTH{1'b0}};
            for (int i = 1; i < TREE_LATENCY; i++) begin
                dl0_tag_q[i] <= dl0_tag_q[i-1];
                dl1_tag_q[i] <= dl1_tag_q[i-1];
            end
        end
    end

    // Result FIFO pointers and occupancy; up to two pushes and one pop per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= {PW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            fifo_cnt_q <= {CW{1'b0}};
        end else begin
            rd_ptr_q   <= rd_ptr_q + PW'(pop_s);
            wr_ptr_q   <= wr_ptr_q + PW'(wr0_s) + PW'(wr1_s);
            fifo_cnt_q <= fifo_cnt_q + CW'(wr0_s) + CW'(wr1_s) - CW'(pop_s);
        end
    end

    // Result FIFO storage; lane 0 lands ahead of lane 1 when both return together.
    always_ff @(posedge clk) begin
        if (wr0_s) begin
            fifo_mem_q[wr_ptr_q] <= entry0_s;
        end
        if (wr1_s) begin
            fifo_mem_q[wr1_ptr_s] <= entry1_s;
        end
    end

    assign bus.node_ready         = (state_q == ST_LOAD);
    assign bus.tree_fsm_enable    = (state_q == ST_LOAD);
    assign bus.tree_sender_enable = node_accept_s;
    assign bus.tree_sender_data   = node_accept_s ? bus.node_data : {INTERNAL_WIDTH{1'b0}};
    assign bus.qa_ready           = qa_ready_s;
    assign bus.qb_ready           = qb_ready_s;
    assign bus.tree_patch_en      = issue_a_s;
    assign bus.tree_patch_two_en  = issue_b_s;
    assign bus.tree_patch_in      = issue_a_s ? bus.qa_patch : {PATCH_WIDTH{1'b0}};
    assign bus.tree_patch_in_two  = issue_b_s ? bus.qb_patch : {PATCH_WIDTH{1'b0}};
    assign bus.res_valid          = res_valid_s;
    assign bus.res_leaf           = res_valid_s ? head_s[EW-1:TAG_WIDTH+1] : {ADDRESS_WIDTH{1'b0}};
    assign bus.res_tag            = res_valid_s ? head_s[TAG_WIDTH:1] : {TAG_WIDTH{1'b0}};
    assign bus.res_lane           = res_valid_s ? head_s[0] : 1'b0;
    assign bus.load_done          = load_done_q;
    assign bus.done               = done_q;
    assign bus.err                = err_q;
endmodule

// File: tb/tb_kd_tree_query_scheduler.sv
// Directed bench for kd_tree_query_scheduler: the bench plays the 6-cycle tree and
// checks results against a scoreboard filled at issue time.
module tb_kd_tree_query_scheduler;
    localparam int PW_C = 55;
    localparam int IW_C = 22;
    localparam int AW_C = 8;
    localparam int TW_C = 8;
    localparam int LAT_C = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    kd_tree_query_scheduler_if #(.PATCH_WIDTH(PW_C), .INTERNAL_WIDTH(IW_C),
                                 .ADDRESS_WIDTH(AW_C), .TAG_WIDTH(TW_C)) bus ();

    kd_tree_query_scheduler #(
        .PATCH_WIDTH(PW_C), .INTERNAL_WIDTH(IW_C), .ADDRESS_WIDTH(AW_C),
        .NUM_NODES(63), .TREE_LATENCY(LAT_C), .TAG_WIDTH(TW_C), .RESULT_DEPTH(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int sent_cnt = 0;
    logic acc_a, acc_b, sent;
    logic [16:0] exp_q[$];
    int ret0_cyc[$];
    int ret1_cyc[$];
    logic [7:0] ret0_leaf[$];
    logic [7:0] ret1_leaf[$];

    function automatic logic [21:0] word(input int i);
        return 22'(i * 3001 + 17);
    endfunction

    function automatic logic [7:0] leaf_of(input logic [54:0] p, input logic lane);
        return lane ? ~p[7:0] : p[7:0];
    endfunction

    function automatic logic [54:0] rnd_patch();
        return 55'({$urandom, $urandom});
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: observe outputs mid-cycle, then advance and play the tree.
    task automatic step();
        logic [16:0] e;
        #1;
        acc_a = bus.tree_patch_en;
        acc_b = bus.tree_patch_two_en;
        sent  = bus.tree_sender_enable;
        if (sent) begin
            chk("sender_data", 64'(bus.tree_sender_data), 64'(word(sent_cnt)));
            sent_cnt++;
        end
        if (acc_a) begin
            chk("patch_a", 64'(bus.tree_patch_in), 64'(bus.qa_patch));
            exp_q.push_back({leaf_of(bus.qa_patch, 1'b0), bus.qa_tag, 1'b0});
            ret0_cyc.push_back(cyc + LAT_C);
            ret0_leaf.push_back(leaf_of(bus.qa_patch, 1'b0));
        end
        if (acc_b) begin
            chk("patch_b", 64'(bus.tree_patch_in_two), 64'(bus.qb_patch));
            exp_q.push_back({leaf_of(bus.qb_patch, 1'b1), bus.qb_tag, 1'b1});
            ret1_cyc.push_back(cyc + LAT_C);
            ret1_leaf.push_back(leaf_of(bus.qb_patch, 1'b1));
        end
        if (bus.res_valid && bus.res_ready) begin
            chk("sb_pending", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("result", 64'({bus.res_leaf, bus.res_tag, bus.res_lane}), 64'(e));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        bus.tree_receiver_en     = 1'b0;
        bus.tree_receiver_two_en = 1'b0;
        bus.tree_leaf_index      = 8'h00;
        bus.tree_leaf_index_two  = 8'h00;
        if (ret0_cyc.size() != 0 && ret0_cyc[0] == cyc) begin
            bus.tree_receiver_en = 1'b1;
            bus.tree_leaf_index  = ret0_leaf.pop_front();
            void'(ret0_cyc.pop_front());
        end
        if (ret1_cyc.size() != 0 && ret1_cyc[0] == cyc) begin
            bus.tree_receiver_two_en = 1'b1;
            bus.tree_leaf_index_two  = ret1_leaf.pop_front();
            void'(ret1_cyc.pop_front());
        end
    endtask

    task automatic load_words();
        int i;
        i = 0;
        sent_cnt = 0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("fsm_en_load", 64'(bus.tree_fsm_enable), 64'(1));
        for (int g = 0; g < 1000 && i < 63; g++) begin
            bus.node_valid = ($urandom_range(0, 3) != 0);
            bus.node_data  = word(i);
            step();
            if (sent) begin
                i++;
                if (i == 63) chk("load_done", 64'(bus.load_done), 64'(1));
            end
        end
        chk("sender_count", 64'(sent_cnt), 64'(63));
        bus.node_valid = 1'b1;
        bus.node_data  = word(63);
        #1;
        chk("node_ready_64", 64'(bus.node_ready), 64'(0));
        chk("sender_en_64", 64'(bus.tree_sender_enable), 64'(0));
        step();
        bus.node_valid = 1'b0;
        chk("load_done_pulse", 64'(bus.load_done), 64'(0));
        chk("sender_count_64", 64'(sent_cnt), 64'(63));
    endtask

    task automatic drain(input int budget);
        bus.qa_valid  = 1'b0;
        bus.qb_valid  = 1'b0;
        bus.res_ready = 1'b1;
        for (int g = 0; g < budget && exp_q.size() != 0; g++) step();
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [54:0] p;
        int issue_cyc, na, nb, ra, done_cnt, extra;
        bus.start = 1'b0; bus.flush = 1'b0; bus.node_valid = 1'b0; bus.node_data = 22'h0;
        bus.qa_valid = 1'b0; bus.qb_valid = 1'b0; bus.qa_patch = 55'h0; bus.qb_patch = 55'h0;
        bus.qa_tag = 8'h00; bus.qb_tag = 8'h00; bus.res_ready = 1'b0;
        bus.tree_receiver_en = 1'b0; bus.tree_receiver_two_en = 1'b0;
        bus.tree_leaf_index = 8'h00; bus.tree_leaf_index_two = 8'h00;

        // Reset state
        #12;
        chk("rst_node_ready", 64'(bus.node_ready), 64'(0));
        chk("rst_res_valid", 64'(bus.res_valid), 64'(0));
        chk("rst_err", 64'(bus.err), 64'(0));
        chk("rst_fsm_en", 64'(bus.tree_fsm_enable), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("idle_flush_ignored", 64'(bus.tree_fsm_enable), 64'(0));

        // LOAD
        load_words();

        // Single A query, tag 0x15, leaf 0x2A
        p = rnd_patch();
        p[7:0] = 8'h2A;
        bus.qa_patch = p; bus.qa_tag = 8'h15; bus.qa_valid = 1'b1; bus.res_ready = 1'b1;
        step();
        chk("single_issue", 64'(acc_a), 64'(1));
        issue_cyc = cyc - 1;
        bus.qa_valid = 1'b0;
        for (int g = 0; g < 15; g++) begin
            #1;
            if (bus.res_valid) break;
            step();
        end
        chk("single_latency", 64'(cyc - issue_cyc), 64'(LAT_C + 1));
        chk("single_leaf", 64'(bus.res_leaf), 64'(8'h2A));
        chk("single_tag", 64'(bus.res_tag), 64'(8'h15));
        chk("single_lane", 64'(bus.res_lane), 64'(0));
        step();
        chk("single_err", 64'(bus.err), 64'(0));

        // Contested last credit: A first, then B
        bus.res_ready = 1'b0;
        na = 0;
        bus.qa_valid = 1'b1;
        for (int g = 0; g < 20 && na < 7; g++) begin
            bus.qa_tag = 8'(8'h30 + na);
            bus.qa_patch = rnd_patch();
            step();
            if (acc_a) na++;
        end
        chk("fill_seven", 64'(na), 64'(7));
        bus.qa_tag = 8'h37; bus.qa_patch = rnd_patch();
        bus.qb_tag = 8'hB0; bus.qb_patch = rnd_patch(); bus.qb_valid = 1'b1;
        step();
        chk("contest1_a", 64'(acc_a), 64'(1));
        chk("contest1_b", 64'(acc_b), 64'(0));
        bus.qa_tag = 8'h38; bus.qa_patch = rnd_patch();
        step();
        chk("full_no_issue", 64'(acc_a | acc_b), 64'(0));
        for (int g = 0; g < 20; g++) begin
            #1;
            if (bus.res_valid) break;
            step();
        end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        step();
        chk("contest2_a", 64'(acc_a), 64'(0));
        chk("contest2_b", 64'(acc_b), 64'(1));
        drain(80);

        // Both lanes continuously valid with a stalled sink
        bus.res_ready = 1'b0;
        bus.qa_valid = 1'b1; bus.qb_valid = 1'b1;
        bus.qa_tag = 8'h40; bus.qb_tag = 8'h80;
        bus.qa_patch = rnd_patch(); bus.qb_patch = rnd_patch();
        na = 0; nb = 0;
        for (int g = 0; g < 20; g++) begin
            step();
            if (acc_a) begin na++; bus.qa_tag = bus.qa_tag + 8'h01; bus.qa_patch = rnd_patch(); end
            if (acc_b) begin nb++; bus.qb_tag = bus.qb_tag + 8'h01; bus.qb_patch = rnd_patch(); end
        end
        chk("stall_accepts_a", 64'(na), 64'(4));
        chk("stall_accepts_b", 64'(nb), 64'(4));
        #1;
        chk("stall_ready_a", 64'(bus.qa_ready), 64'(0));
        chk("stall_ready_b", 64'(bus.qb_ready), 64'(0));
        bus.res_ready = 1'b1;
        ra = 0;
        for (int g = 0; g < 30; g++) begin
            step();
            if (acc_a) begin ra++; bus.qa_tag = bus.qa_tag + 8'h01; bus.qa_patch = rnd_patch(); end
            if (acc_b) begin ra++; bus.qb_tag = bus.qb_tag + 8'h01; bus.qb_patch = rnd_patch(); end
        end
        chk("issue_resumes", 64'(ra > 0), 64'(1));
        drain(80);

        // Flush with three queries in flight
        bus.res_ready = 1'b1;
        bus.qa_valid = 1'b1; bus.qb_valid = 1'b1;
        bus.qa_tag = 8'hC0; bus.qb_tag = 8'hD0;
        bus.qa_patch = rnd_patch(); bus.qb_patch = rnd_patch();
        step();
        chk("flush_pre_ab", 64'({acc_a, acc_b}), 64'(2'b11));
        bus.qb_valid = 1'b0; bus.qa_tag = 8'hC1; bus.qa_patch = rnd_patch();
        step();
        chk("flush_pre_a", 64'(acc_a), 64'(1));
        bus.flush = 1'b1; bus.qb_valid = 1'b1; bus.qa_tag = 8'hC2;
        step();
        chk("flush_cycle_no_issue", 64'(acc_a | acc_b), 64'(0));
        bus.flush = 1'b0;
        done_cnt = 0; extra = 0;
        for (int g = 0; g < 40; g++) begin
            step();
            if (acc_a || acc_b) extra++;
            if (bus.done) done_cnt++;
        end
        chk("drain_no_issue", 64'(extra), 64'(0));
        chk("done_once", 64'(done_cnt), 64'(1));
        chk("flush_results_out", 64'(exp_q.size()), 64'(0));
        bus.qa_valid = 1'b0; bus.qb_valid = 1'b0;
        chk("idle_after_drain", 64'(bus.tree_fsm_enable), 64'(0));
        load_words();

        // Asynchronous reset mid-QUERY
        bus.res_ready = 1'b0;
        bus.qa_valid = 1'b1; bus.qa_tag = 8'hE0; bus.qa_patch = rnd_patch();
        for (int g = 0; g < 20; g++) begin
            step();
            if (bus.res_valid) break;
        end
        chk("pre_rst_res_valid", 64'(bus.res_valid), 64'(1));
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_qa_ready", 64'(bus.qa_ready), 64'(0));
        chk("arst_patch_en", 64'(bus.tree_patch_en), 64'(0));
        chk("arst_patch_in", 64'(bus.tree_patch_in), 64'(0));
        chk("arst_res_valid", 64'(bus.res_valid), 64'(0));
        chk("arst_res_leaf", 64'(bus.res_leaf), 64'(0));
        chk("arst_res_tag", 64'(bus.res_tag), 64'(0));
        chk("arst_fsm_en", 64'(bus.tree_fsm_enable), 64'(0));
        chk("arst_err", 64'(bus.err), 64'(0));
        chk("arst_done", 64'(bus.done | bus.load_done), 64'(0));
        exp_q.delete(); ret0_cyc.delete(); ret1_cyc.delete();
        ret0_leaf.delete(); ret1_leaf.delete();
        bus.qa_valid = 1'b0;
        bus.tree_receiver_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.tree_receiver_en = 1'b1;
        bus.tree_leaf_index = 8'h11;
        @(posedge clk);
        #1;
        bus.tree_receiver_en = 1'b0;
        chk("rogue_err", 64'(bus.err), 64'(1));
        step(); step(); step();
        chk("err_sticky", 64'(bus.err), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
